ar_id_remap_queue: RTL and testbench

Parametrised successor to the single-request AR ID ordering unit. Buffers up to `DEPTH` AXI read-address requests from the master, obtains a unique ID for the head request from `allocator_tag_map`, and forwards requests to the slave in arrival order with ARID replaced by the unique ID. A 2-entry registered output buffer keeps `m_ar` stable and sustains one request per cycle. `REMAP_EN=0` selects a pass-through mode with no allocator traffic.

---
 rtl/ar_id_remap_queue.sv | 173 +++++++++++++++++
 tb/tb_ar_id_remap_queue.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ar_id_remap_queue.sv
// Purpose: buffers AXI AR requests, swaps ARID for an allocator-issued unique ID, forwards them in order.
// Latency: 2 cycles minimum from s_ar push to m_ar valid (push -> alloc_req -> output register).
// Backpressure: s_ar_ready drops when the queue is full; allocator grants stall while the 2-entry output buffer is full.
module ar_id_remap_queue #(
    parameter int ID_WIDTH   = 4,
    parameter int UID_WIDTH  = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int DEPTH      = 4,
    parameter int REMAP_EN   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    // AR channel from the master
    input  logic                         s_ar_valid,
    output logic                         s_ar_ready,
    input  logic [ID_WIDTH-1:0]          s_ar_id,
    input  logic [ADDR_WIDTH-1:0]        s_ar_addr,
    input  logic [LEN_WIDTH-1:0]         s_ar_len,
    input  logic [2:0]                   s_ar_size,
    input  logic [1:0]                   s_ar_burst,
    // AR channel to the slave
    output logic                         m_ar_valid,
    input  logic                         m_ar_ready,
    output logic [UID_WIDTH-1:0]         m_ar_id,
    output logic [ADDR_WIDTH-1:0]        m_ar_addr,
    output logic [LEN_WIDTH-1:0]         m_ar_len,
    output logic [2:0]                   m_ar_size,
    output logic [1:0]                   m_ar_burst,
    // unique-ID allocator
    output logic                         alloc_req,
    output logic [ID_WIDTH-1:0]          alloc_in_id,
    input  logic                         alloc_gnt,
    input  logic [UID_WIDTH-1:0]         unique_id,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam bit REMAP = (REMAP_EN != 0);

    // input queue storage
    logic [ID_WIDTH-1:0]   q_id    [DEPTH];
    logic [ADDR_WIDTH-1:0] q_addr  [DEPTH];
    logic [LEN_WIDTH-1:0]  q_len   [DEPTH];
    logic [2:0]            q_size  [DEPTH];
    logic [1:0]            q_burst [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // output buffer storage
    logic [UID_WIDTH-1:0]  ob_id    [2];
    logic [ADDR_WIDTH-1:0] ob_addr  [2];
    logic [LEN_WIDTH-1:0]  ob_len   [2];
    logic [2:0]            ob_size  [2];
    logic [1:0]            ob_burst [2];

    logic       ob_wr;
    logic       ob_rd;
    logic [1:0] out_cnt;

    logic                 push;
    logic                 xfer_ok;
    logic                 xfer;
    logic                 out_pop;
    logic [UID_WIDTH-1:0] xfer_id;

    // Ready is held low while reset is asserted; otherwise it depends only on the registered count.
    assign s_ar_ready = rst && (count != CNT_W'(DEPTH));
    assign push       = s_ar_valid && s_ar_ready;

    // A head entry can move to the output buffer whenever there is room for it.
    assign xfer_ok = (count != '0) && (out_cnt != 2'd2);
    assign xfer    = REMAP ? (xfer_ok && alloc_gnt) : xfer_ok;

    assign alloc_req   = REMAP ? xfer_ok : 1'b0;
    assign alloc_in_id = q_id[rd_ptr];
    assign xfer_id     = REMAP ? unique_id : UID_WIDTH'(q_id[rd_ptr]);

    assign occupancy = count;

    assign m_ar_valid = (out_cnt != 2'd0);
    assign out_pop    = m_ar_valid && m_ar_ready;

    assign m_ar_id    = ob_id[ob_rd];
    assign m_ar_addr  = ob_addr[ob_rd];
    assign m_ar_len   = ob_len[ob_rd];
    assign m_ar_size  = ob_size[ob_rd];
    assign m_ar_burst = ob_burst[ob_rd];

    // Queue storage write; cleared on reset so alloc_in_id reads zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_id[i]    <= '0;
                q_addr[i]  <= '0;
                q_len[i]   <= '0;
                q_size[i]  <= '0;
                q_burst[i] <= '0;
            end
        end else if (push) begin
            q_id[wr_ptr]    <= s_ar_id;
            q_addr[wr_ptr]  <= s_ar_addr;
            q_len[wr_ptr]   <= s_ar_len;
            q_size[wr_ptr]  <= s_ar_size;
            q_burst[wr_ptr] <= s_ar_burst;
        end
    end

    // Queue pointers wrap at DEPTH-1 so non-power-of-2 depths work; count tracks push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (xfer) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, xfer})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Output buffer write; the head entry moves in with its remapped (or zero-extended) ID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                ob_id[i]    <= '0;
                ob_addr[i]  <= '0;
                ob_len[i]   <= '0;
                ob_size[i]  <= '0;
                ob_burst[i] <= '0;
            end
        end else if (xfer) begin
            ob_id[ob_wr]    <= xfer_id;
            ob_addr[ob_wr]  <= q_addr[rd_ptr];
            ob_len[ob_wr]   <= q_len[rd_ptr];
            ob_size[ob_wr]  <= q_size[rd_ptr];
            ob_burst[ob_wr] <= q_burst[rd_ptr];
        end
    end

    // Output buffer pointers and occupancy; a simultaneous write and read leaves out_cnt unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ob_wr   <= 1'b0;
            ob_rd   <= 1'b0;
            out_cnt <= 2'd0;
        end else begin
            if (xfer) begin
                ob_wr <= ~ob_wr;
            end
            if (out_pop) begin
                ob_rd <= ~ob_rd;
            end
            case ({xfer, out_pop})
                2'b10:   out_cnt <= out_cnt + 2'd1;
                2'b01:   out_cnt <= out_cnt - 2'd1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ar_id_remap_queue.sv
// Purpose: directed self-checking bench for ar_id_remap_queue (remap instance plus pass-through instance).
// Latency: expects alloc_req one cycle after a push and m_ar_valid one cycle after a grant.
// Backpressure: exercises full input queue, full output buffer and toggling m_ar_ready.
module tb_ar_id_remap_queue;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } req_t;

    logic clk;
    logic rst;

    // remapping instance
    logic        a_s_valid, a_s_ready;
    logic [3:0]  a_s_id;
    logic [31:0] a_s_addr;
    logic [7:0]  a_s_len;
    logic        a_m_valid, a_m_ready;
    logic [7:0]  a_m_id;
    logic [31:0] a_m_addr;
    logic [7:0]  a_m_len;
    logic [2:0]  a_m_size;
    logic [1:0]  a_m_burst;
    logic        a_req, a_gnt;
    logic [3:0]  a_in_id;
    logic [7:0]  a_uid;
    logic [2:0]  a_occ;

    // pass-through instance
    logic        b_s_valid, b_s_ready;
    logic [3:0]  b_s_id;
    logic        b_m_valid, b_m_ready;
    logic [7:0]  b_m_id;
    logic [31:0] b_m_addr;
    logic [7:0]  b_m_len;
    logic [2:0]  b_m_size;
    logic [1:0]  b_m_burst;
    logic        b_req;
    logic [3:0]  b_in_id;
    logic [2:0]  b_occ;

    logic [7:0]  uid_off;
    int          n_chk;
    int          n_fail;
    int          n_out;
    bit          b_req_seen;

    req_t        exp_in[$];
    logic [52:0] exp_out[$];
    bit          prev_stall;
    logic [52:0] prev_fields;
    bit          prev_req_wait;
    logic [3:0]  prev_in_id;

    // allocator stand-in: unique ID is an offset applied to the requested ARID
    assign a_uid = uid_off + {4'b0, a_in_id};

    ar_id_remap_queue #(.DEPTH(4), .REMAP_EN(1)) dut_a (
        .clk(clk), .rst(rst),
        .s_ar_valid(a_s_valid), .s_ar_ready(a_s_ready), .s_ar_id(a_s_id),
        .s_ar_addr(a_s_addr), .s_ar_len(a_s_len), .s_ar_size(3'd2), .s_ar_burst(2'b01),
        .m_ar_valid(a_m_valid), .m_ar_ready(a_m_ready), .m_ar_id(a_m_id),
        .m_ar_addr(a_m_addr), .m_ar_len(a_m_len), .m_ar_size(a_m_size), .m_ar_burst(a_m_burst),
        .alloc_req(a_req), .alloc_in_id(a_in_id), .alloc_gnt(a_gnt), .unique_id(a_uid),
        .occupancy(a_occ)
    );

    ar_id_remap_queue #(.DEPTH(4), .REMAP_EN(0)) dut_b (
        .clk(clk), .rst(rst),
        .s_ar_valid(b_s_valid), .s_ar_ready(b_s_ready), .s_ar_id(b_s_id),
        .s_ar_addr(32'h0000_3000), .s_ar_len(8'd1), .s_ar_size(3'd2), .s_ar_burst(2'b01),
        .m_ar_valid(b_m_valid), .m_ar_ready(b_m_ready), .m_ar_id(b_m_id),
        .m_ar_addr(b_m_addr), .m_ar_len(b_m_len), .m_ar_size(b_m_size), .m_ar_burst(b_m_burst),
        .alloc_req(b_req), .alloc_in_id(b_in_id), .alloc_gnt(1'b1), .unique_id(8'hEE),
        .occupancy(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: samples handshakes mid-cycle, when inputs are settled for the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            if (a_m_valid && a_m_ready) begin
                if (exp_out.size() == 0) begin
                    chk("unexpected_m_ar", 64'd1, 64'd0);
                end else begin
                    chk("m_ar_fields", {a_m_id, a_m_addr, a_m_len, a_m_size, a_m_burst}, exp_out.pop_front());
                end
                n_out++;
            end
            if (prev_stall) begin
                chk("stall_valid", a_m_valid, 1);
                chk("stall_fields", {a_m_id, a_m_addr, a_m_len, a_m_size, a_m_burst}, prev_fields);
            end
            prev_stall  = a_m_valid && !a_m_ready;
            prev_fields = {a_m_id, a_m_addr, a_m_len, a_m_size, a_m_burst};
            if (prev_req_wait) begin
                chk("alloc_stable", {a_req, a_in_id}, {1'b1, prev_in_id});
            end
            prev_req_wait = a_req && !a_gnt;
            prev_in_id    = a_in_id;
            if (a_req && a_gnt) begin
                if (exp_in.size() == 0) begin
                    chk("unexpected_grant", 64'd1, 64'd0);
                end else begin
                    req_t r;
                    r = exp_in.pop_front();
                    chk("alloc_in_id", a_in_id, r.id);
                    exp_out.push_back({uid_off + {4'b0, r.id}, r.addr, r.len, 3'd2, 2'b01});
                end
            end
            if (a_s_valid && a_s_ready) begin
                exp_in.push_back('{id: a_s_id, addr: a_s_addr, len: a_s_len});
            end
            if (b_req) b_req_seen = 1'b1;
        end else begin
            exp_in.delete();
            exp_out.delete();
            prev_stall    = 1'b0;
            prev_req_wait = 1'b0;
        end
    end

    initial begin
        int n0;
        int pushed;
        rst = 1'b0;
        a_s_valid = 0; a_s_id = 0; a_s_addr = 0; a_s_len = 0;
        a_m_ready = 0; a_gnt = 0; uid_off = 0;
        b_s_valid = 0; b_s_id = 0; b_m_ready = 0;
        n_chk = 0; n_fail = 0; n_out = 0; b_req_seen = 0;
        prev_stall = 0; prev_req_wait = 0; prev_fields = '0; prev_in_id = '0;

        // reset state
        #22;
        chk("rst_s_ready", a_s_ready, 0);
        chk("rst_m_valid", a_m_valid, 0);
        chk("rst_alloc_req", a_req, 0);
        chk("rst_occupancy", a_occ, 0);
        chk("rst_m_id", a_m_id, 0);
        chk("rst_alloc_in_id", a_in_id, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("release_s_ready", a_s_ready, 1);
        step();

        // single request: id=3 remapped to 0x5A
        a_s_valid = 1; a_s_id = 4'd3; a_s_addr = 32'h1000; a_s_len = 8'd7;
        step();
        a_s_valid = 0;
        chk("single_alloc_req", a_req, 1);
        chk("single_alloc_in_id", a_in_id, 3);
        chk("single_m_valid_early", a_m_valid, 0);
        uid_off = 8'h57; a_gnt = 1;
        step();
        a_gnt = 0;
        chk("single_m_valid", a_m_valid, 1);
        chk("single_m_id", a_m_id, 8'h5A);
        chk("single_m_addr", a_m_addr, 32'h1000);
        chk("single_m_len", a_m_len, 7);
        a_m_ready = 1;
        step();
        a_m_ready = 0;
        chk("single_drained", a_m_valid, 0);

        // pass-through: id=0xF appears as 0x0F two cycles later, no allocator traffic
        b_s_valid = 1; b_s_id = 4'hF;
        step();
        b_s_valid = 0;
        chk("pt_alloc_req", b_req, 0);
        chk("pt_m_valid_early", b_m_valid, 0);
        step();
        chk("pt_m_valid", b_m_valid, 1);
        chk("pt_m_id", b_m_id, 8'h0F);
        b_m_ready = 1;
        step();
        b_m_ready = 0;

        // fill to full, then full output buffer blocks further grants
        uid_off = 8'h20; n0 = n_out;
        for (int k = 1; k <= 4; k++) begin
            a_s_valid = 1; a_s_id = 4'(k); a_s_addr = 32'(k * 256); a_s_len = 8'(k);
            step();
        end
        a_s_valid = 1; a_s_id = 4'd5; a_s_addr = 32'h500; a_s_len = 8'd5;
        chk("full_s_ready", a_s_ready, 0);
        chk("full_occupancy", a_occ, 4);
        step();
        chk("full_held_occ", a_occ, 4);
        chk("full_head_id", a_in_id, 1);
        a_gnt = 1;
        step();
        a_gnt = 0;
        chk("full_after_pop_occ", a_occ, 3);
        step();
        chk("full_push5_occ", a_occ, 4);
        a_s_id = 4'd6; a_s_addr = 32'h600; a_s_len = 8'd6;
        a_gnt = 1;
        step();
        a_gnt = 0;
        step();
        a_s_id = 4'd7; a_s_addr = 32'h700; a_s_len = 8'd7;
        chk("outfull_alloc_req", a_req, 0);
        chk("outfull_s_ready", a_s_ready, 0);
        a_gnt = 1;
        step();
        chk("outfull_occ", a_occ, 4);
        chk("outfull_s_ready2", a_s_ready, 0);
        a_s_valid = 0;
        a_m_ready = 1;
        for (int i = 0; i < 40; i++) begin
            if (a_occ == 0 && !a_m_valid) break;
            step();
        end
        chk("fill_drain_count", n_out - n0, 6);
        a_gnt = 0; a_m_ready = 0;

        // back-pressure and ordering: ids 0..7 -> uids 0x10..0x17
        uid_off = 8'h10; n0 = n_out; pushed = 0; a_gnt = 1;
        for (int c = 0; c < 80; c++) begin
            if (pushed == 8 && n_out - n0 == 8) break;
            a_s_valid = (pushed < 8);
            a_s_id = 4'(pushed); a_s_addr = 32'h2000 + 32'(pushed * 16); a_s_len = 8'(pushed);
            a_m_ready = c[0];
            if (a_s_valid && a_s_ready) pushed++;
            step();
        end
        a_s_valid = 0;
        chk("bp_count", n_out - n0, 8);
        a_gnt = 0; a_m_ready = 0;

        // streaming: one handshake per cycle after a 2-cycle fill
        uid_off = 8'h40; a_gnt = 1; a_m_ready = 1;
        for (int t = 0; t < 13; t++) begin
            a_s_valid = (t < 10);
            a_s_id = 4'(t); a_s_addr = 32'h4000 + 32'(t); a_s_len = 8'(t);
            chk("stream_occ_le1", a_occ <= 1, 1);
            chk("stream_m_valid", a_m_valid, (t >= 2 && t <= 11));
            step();
        end
        a_s_valid = 0; a_gnt = 0; a_m_ready = 0;

        // reset mid-operation: 3 queued, 2 in the output buffer
        uid_off = 8'h60;
        for (int k = 1; k <= 2; k++) begin
            a_s_valid = 1; a_s_id = 4'(k); a_s_addr = 32'h5000 + 32'(k); a_s_len = 8'(k);
            step();
        end
        a_s_valid = 0; a_gnt = 1;
        step();
        step();
        a_gnt = 0;
        for (int k = 3; k <= 5; k++) begin
            a_s_valid = 1; a_s_id = 4'(k); a_s_addr = 32'h5000 + 32'(k); a_s_len = 8'(k);
            step();
        end
        a_s_valid = 0;
        chk("pre_rst_occ", a_occ, 3);
        chk("pre_rst_m_valid", a_m_valid, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_m_valid", a_m_valid, 0);
        chk("mid_rst_occ", a_occ, 0);
        chk("mid_rst_s_ready", a_s_ready, 0);
        chk("mid_rst_alloc_req", a_req, 0);
        step();
        rst = 1'b1;
        n0 = n_out; a_gnt = 1; a_m_ready = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_m_valid", a_m_valid, 0);
        end
        chk("post_rst_no_output", n_out - n0, 0);
        chk("pt_alloc_never", b_req_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
